simmem_wresp_bank: RTL
======================

// Module: simmem_wresp_bank
// PURPOSE
// - Write-response bank downstream of simmem_delay_calculator.
// - Reserves one internal identifier (iid) per accepted write address and stores the real memory's write response in that slot.
// - Holds each response until the delay calculator asserts its wresp_release_en bit.
// - Emits responses towards the requester in per-AXI-ID order and returns the released slot as a one-hot to the delay calculator.
// PARAMETERS
// - Capacity   16 : number of slots; equals simmem_pkg::WriteRespBankCapacity.
// - IdWidth     4 : AXI ID width.
// - DataWidth   2 : response payload width (BRESP).
// - IidWidth  $clog2(Capacity) : iid width (localparam).
// PORTS
// - clk_i                   in   1          : clock.
// - rst_i                   in   1          : synchronous reset, active-high.
// - rsv_valid_i             in   1          : reservation request; one per accepted write address.
// - rsv_ready_o             out  1          : a free slot exists.
// - rsv_id_i                in   IdWidth    : AXI ID of the reserving write.
// - rsv_iid_o               out  IidWidth   : iid granted; feeds waddr_iid_i of the delay calculator.
// - in_valid_i              in   1          : response from the real memory.
// - in_ready_o              out  1          : a matching reserved, data-less slot exists.
// - in_id_i                 in   IdWidth    : response AXI ID.
// - in_data_i               in   DataWidth  : response payload.
// - release_en_i            in   Capacity   : per-slot release enable from the delay calculator.
// - out_valid_o             out  1          : a releasable response is presented.
// - out_ready_i             in   1          : requester accepts the response.
// - out_id_o                out  IdWidth    : released AXI ID.
// - out_data_o              out  DataWidth  : released payload.
// - released_addr_onehot_o  out  Capacity   : one-hot of the slot released this cycle; all zeros otherwise.
// BEHAVIOUR
// - Slot state:
//   - Each slot holds: rsv (reserved), dv (data valid), id, data.
//   - The bank keeps a Capacity x Capacity age matrix: older[i][j]=1 means slot i was reserved before slot j.
// - Reset (synchronous, rst_i=1 at a clock edge): every rsv and dv bit clears and the age matrix clears.
// - Output values after reset:
//   - rsv_ready_o=1; rsv_iid_o=0.
//   - in_ready_o=0; out_valid_o=0.
//   - out_id_o and out_data_o are 0.
//   - released_addr_onehot_o=0.
// - Reset mid-operation drops all held responses without releasing any of them.
// - Reservation:
//   - rsv_iid_o is the lowest-index slot with rsv=0, derived combinationally from registered state.
//   - rsv_ready_o = |(~rsv).
//   - On rsv_valid_i & rsv_ready_o the slot takes rsv=1, dv=0 and id=rsv_id_i at the next edge.
//   - At the same edge that slot becomes younger than every currently reserved slot.
//   - Full: rsv_ready_o=0 and rsv_iid_o holds the value 0.
// - Response input:
//   - The target slot is the oldest slot with rsv=1, dv=0 and id==in_id_i.
//   - in_ready_o=1 only when a target slot exists; in_ready_o may depend combinationally on in_id_i.
//   - On handshake the slot takes dv=1 and data=in_data_i at the next edge.
//   - Responses with the same ID arrive in reservation order.
// - Release eligibility: a slot is eligible when all of the following hold:
//   - rsv=1 and dv=1;
//   - its release_en_i bit is 1;
//   - no older slot with rsv=1 has the same id. This enforces AXI same-ID ordering; an older same-ID slot blocks the slot even if the older slot has no data yet.
// - Output:
//   - out_valid_o = any eligible slot.
//   - The bank presents the oldest eligible slot; with registered state, no two reserved slots are ever equally old.
//   - out_valid_o, once high, stays high with stable id and data until out_ready_i; release_en_i must not drop for a presented slot.
//   - On the out_valid_o & out_ready_i handshake:
//     - released_addr_onehot_o carries that slot's one-hot in the same cycle;
//     - rsv and dv clear at the next edge;
//     - the age row and column of the slot clear.
// - Latency:
//   - A reserved slot accepts a response from the next cycle onwards.
//   - A stored response is eligible from the cycle after storage, if release_en_i is set.
//   - A released slot can be reserved from the cycle after release.
// - Simultaneous events in one cycle (reserve, store, release) are legal on distinct slots.
// - The store target is never the reserve target in the same cycle, because the reserve target has rsv=0.
// - A freed slot is not re-reservable in its release cycle.
// CONFIGURATION
// - SIMMEM_WRESP_RELEASE_BYPASS_EN defined:
//   - release_en_i is ignored and treated as all ones.
//   - Responses leave as soon as they are stored and ID ordering allows; this is the zero-delay reference mode.
// - SIMMEM_WRESP_RELEASE_BYPASS_EN undefined: release is gated by release_en_i as described above.
// TESTING
// 1. Reset:
//    - rst_i=1 for 2 cycles -> rsv_ready_o=1, rsv_iid_o=0, out_valid_o=0, released_addr_onehot_o=0.
// 2. Single response:
//    - Reserve id=3 -> iid 0; store data=2'b10; hold release_en_i=0 for 5 cycles -> out_valid_o stays 0.
//    - Set release_en_i[0]=1 -> out_valid_o=1, out_id_o=3, out_data_o=2'b10.
//    - With out_ready_i=1 -> released_addr_onehot_o=16'h0001.
// 3. Fill:
//    - 16 reservations -> rsv_ready_o=0.
//    - Release slot 5 -> the next cycle rsv_ready_o=1 and rsv_iid_o=5.
// 4. Same-ID ordering:
//    - Reserve A (id=1), then B (id=1); store both; set release_en_i for B only -> out_valid_o=0.
//    - Add release_en_i for A -> A is released first, then B.
// 5. Different IDs:
//    - Reserve A (id=1), then B (id=2); store both; release_en_i for B only -> B is released first.
//    - Hold out_ready_i=0 for 3 cycles -> out_id_o/out_data_o stay stable.
// 6. Bypass mode (SIMMEM_WRESP_RELEASE_BYPASS_EN defined):
//    - release_en_i=0 throughout; store a response -> out_valid_o=1 in the next cycle.

Source files
------------

// File: rtl/simmem_wresp_bank.sv
// Write-response bank: reserves one slot per write address, holds the memory response
// until released, and emits responses in per-AXI-ID order. Optional macro: SIMMEM_WRESP_RELEASE_BYPASS_EN.
module simmem_wresp_bank #(
    parameter int Capacity  = 16,
    parameter int IdWidth   = 4,
    parameter int DataWidth = 2,
    localparam int IidWidth = $clog2(Capacity)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 rsv_valid_i,
    output logic                 rsv_ready_o,
    input  logic [IdWidth-1:0]   rsv_id_i,
    output logic [IidWidth-1:0]  rsv_iid_o,

    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [IdWidth-1:0]   in_id_i,
    input  logic [DataWidth-1:0] in_data_i,

    input  logic [Capacity-1:0]  release_en_i,

    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [IdWidth-1:0]   out_id_o,
    output logic [DataWidth-1:0] out_data_o,

    output logic [Capacity-1:0]  released_addr_onehot_o
);

    logic [Capacity-1:0]                r_rsv;
    logic [Capacity-1:0]                r_dv;
    logic [Capacity-1:0][IdWidth-1:0]   r_id;
    logic [Capacity-1:0][DataWidth-1:0] r_data;
    // r_older[i][j] = 1 : slot i was reserved before slot j
    logic [Capacity-1:0][Capacity-1:0]  r_older;
    logic                               r_lock;
    logic [Capacity-1:0]                r_lock_oh;

    logic [Capacity-1:0]                w_en;
    logic [Capacity-1:0][Capacity-1:0]  w_older_col;
    logic [Capacity-1:0][Capacity-1:0]  w_older_nxt;
    logic [Capacity-1:0]                w_rsv_oh;
    logic [IidWidth-1:0]                w_rsv_iid;
    logic                               w_rsv_found;
    logic [Capacity-1:0]                w_in_cand;
    logic [Capacity-1:0]                w_in_oh;
    logic [Capacity-1:0]                w_blk;
    logic [Capacity-1:0]                w_elig;
    logic [Capacity-1:0]                w_pick;
    logic [Capacity-1:0]                w_out_oh;
    logic [Capacity-1:0]                w_rel;
    logic                               w_rsv_fire;
    logic                               w_in_fire;
    logic                               w_out_fire;

`ifdef SIMMEM_WRESP_RELEASE_BYPASS_EN
    assign w_en = '1;
`else
    assign w_en = release_en_i;
`endif

    always_comb begin
        w_older_col = '0;
        for (int i = 0; i < Capacity; i++)
            for (int j = 0; j < Capacity; j++)
                w_older_col[i][j] = r_older[j][i];
    end

    always_comb begin
        w_rsv_oh    = '0;
        w_rsv_iid   = '0;
        w_rsv_found = 1'b0;
        for (int i = 0; i < Capacity; i++) begin
            if (!r_rsv[i] && !w_rsv_found) begin
                w_rsv_found = 1'b1;
                w_rsv_iid   = IidWidth'(i);
                w_rsv_oh[i] = 1'b1;
            end
        end
    end

    assign rsv_ready_o = |(~r_rsv);
    assign rsv_iid_o   = w_rsv_iid;

    // Store target: the oldest reserved, data-less slot of the response ID
    always_comb begin
        w_in_cand = '0;
        w_in_oh   = '0;
        for (int i = 0; i < Capacity; i++)
            w_in_cand[i] = r_rsv[i] & ~r_dv[i] & (r_id[i] == in_id_i);
        for (int i = 0; i < Capacity; i++)
            w_in_oh[i] = w_in_cand[i] & ~(|(w_in_cand & w_older_col[i]));
    end

    assign in_ready_o = |w_in_cand;

    // An older same-ID reservation blocks release, data or not
    always_comb begin
        w_blk  = '0;
        w_pick = '0;
        for (int i = 0; i < Capacity; i++)
            for (int j = 0; j < Capacity; j++)
                if (r_rsv[j] && r_older[j][i] && (r_id[j] == r_id[i]))
                    w_blk[i] = 1'b1;
        w_elig = r_rsv & r_dv & w_en & ~w_blk;
        for (int i = 0; i < Capacity; i++)
            w_pick[i] = w_elig[i] & ~(|(w_elig & w_older_col[i]));
    end

    // A stalled presentation is locked so a newly eligible older slot cannot displace it
    assign w_out_oh    = r_lock ? r_lock_oh : w_pick;
    assign out_valid_o = |w_out_oh;

    always_comb begin
        out_id_o   = '0;
        out_data_o = '0;
        for (int i = 0; i < Capacity; i++) begin
            out_id_o   = out_id_o   | (r_id[i]   & {IdWidth{w_out_oh[i]}});
            out_data_o = out_data_o | (r_data[i] & {DataWidth{w_out_oh[i]}});
        end
    end

    assign w_rsv_fire             = rsv_valid_i & rsv_ready_o;
    assign w_in_fire              = in_valid_i & in_ready_o;
    assign w_out_fire             = out_valid_o & out_ready_i;
    assign w_rel                  = w_out_fire ? w_out_oh : '0;
    assign released_addr_onehot_o = w_rel;

    always_comb begin
        w_older_nxt = r_older;
        for (int i = 0; i < Capacity; i++) begin
            for (int j = 0; j < Capacity; j++) begin
                if (w_rel[i] || w_rel[j])
                    w_older_nxt[i][j] = 1'b0;
                else if (w_rsv_fire && w_rsv_oh[j] && r_rsv[i])
                    w_older_nxt[i][j] = 1'b1;
                else if (w_rsv_fire && w_rsv_oh[i])
                    w_older_nxt[i][j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsv     <= '0;
            r_dv      <= '0;
            r_id      <= '0;
            r_data    <= '0;
            r_older   <= '0;
            r_lock    <= 1'b0;
            r_lock_oh <= '0;
        end else begin
            for (int i = 0; i < Capacity; i++) begin
                if (w_rel[i]) begin
                    r_rsv[i] <= 1'b0;
                    r_dv[i]  <= 1'b0;
                end
                if (w_rsv_fire && w_rsv_oh[i]) begin
                    r_rsv[i] <= 1'b1;
                    r_dv[i]  <= 1'b0;
                    r_id[i]  <= rsv_id_i;
                end
                if (w_in_fire && w_in_oh[i]) begin
                    r_dv[i]   <= 1'b1;
                    r_data[i] <= in_data_i;
                end
            end
            r_older   <= w_older_nxt;
            r_lock    <= out_valid_o & ~out_ready_i;
            r_lock_oh <= w_out_oh;
        end
    end

endmodule
